program_memory_sync: RTL and testbench

- Synchronous-read, parametrised instruction memory for the MIPS fetch stage.
- Converts byte addresses (offset from a text-segment base) to word indices and flags misaligned or out-of-range fetches.
- Provides a word-serial load port so a bootloader (UART or testbench) can write a new program at run time without resynthesis.
- Fetch has 1-cycle registered latency with a valid flag; fetches are blocked while a load is in progress.

---
 rtl/program_memory_sync.sv | 123 ++++++++++++
 tb/tb_program_memory_sync.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory_sync.sv
// Synchronous-read instruction memory for the MIPS fetch stage with a
// word-serial load port for run-time program download.
module program_memory_sync #(
    parameter int                    MEMORY_DEPTH = 64,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD     = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic                  instr_valid,
    output logic                  addr_error,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic                  load_last,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  busy
);

    localparam int PTR_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

    typedef enum logic [1:0] {S_RUN, S_LOAD, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic                    instr_valid_q, instr_valid_d;
    logic                    addr_error_q, addr_error_d;

    logic [DATA_WIDTH-1:0]   rom [MEMORY_DEPTH];
    logic                    rom_we;
    logic [ADDR_WIDTH-1:0]   off;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [PTR_W-1:0]        rd_idx;
    logic                    fetch_bad;

    // Address decode: offset wraps modulo 2^ADDR_WIDTH, so addresses below
    // the base land far out of range and are flagged like any other overrun.
    always_comb begin
        off       = Address - BASE_ADDRESS;
        idx       = off >> 2;
        rd_idx    = idx[PTR_W-1:0];
        fetch_bad = (Address[1:0] != 2'b00) || (idx >= ADDR_WIDTH'(MEMORY_DEPTH));
    end

    // Next-state, load write enable and fetch response.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        addr_error_d  = addr_error_q;
        rom_we        = 1'b0;

        case (state_q)
            S_RUN: begin
                if (fetch_req) begin
                    instr_d       = fetch_bad ? NOP_WORD : rom[rd_idx];
                    addr_error_d  = fetch_bad;
                    instr_valid_d = 1'b1;
                end
                if (load_start) begin
                    state_d  = S_LOAD;
                    wr_ptr_d = '0;
                end
            end
            S_LOAD: begin
                if (load_valid) begin
                    rom_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    // Last word either flagged by the loader or the array is full.
                    if (load_last || (wr_ptr_q == PTR_W'(MEMORY_DEPTH - 1)))
                        state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_RUN;
            default: state_d = S_RUN;
        endcase

        // Fetches while loading are dropped; the requester retries later.
        if ((state_q != S_RUN) && fetch_req) begin
            instr_d      = NOP_WORD;
            addr_error_d = 1'b0;
        end
    end

    // Control and output registers, asynchronously reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_RUN;
            wr_ptr_q      <= '0;
            instr_q       <= NOP_WORD;
            instr_valid_q <= 1'b0;
            addr_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            addr_error_q  <= addr_error_d;
        end
    end

    // Program storage; deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (rom_we)
            rom[wr_ptr_q] <= load_data;
    end

    assign Instruction = instr_q;
    assign instr_valid = instr_valid_q;
    assign addr_error  = addr_error_q;
    assign load_ready  = (state_q == S_LOAD);
    assign load_done   = (state_q == S_DONE);
    assign busy        = (state_q != S_RUN);

endmodule

// File: tb/tb_program_memory_sync.sv
// Randomised self-checking bench for program_memory_sync with a
// behavioural memory/loader model.
module tb_program_memory_sync;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic        instr_valid;
    logic        addr_error;
    logic        load_start;
    logic        load_valid;
    logic        load_last;
    logic [31:0] load_data;
    logic        load_ready;
    logic        load_done;
    logic        busy;

    program_memory_sync dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .Address(Address),
        .Instruction(Instruction), .instr_valid(instr_valid), .addr_error(addr_error),
        .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
        .load_data(load_data), .load_ready(load_ready), .load_done(load_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: mode 0 = running, 1 = loading, 2 = load finished.
    int          m_mode;
    int          m_ptr;
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    logic [31:0] m_instr;
    bit          m_valid;
    bit          m_err;
    bit          m_defined;  // instr/err are pinned down by the specification
    bit          m_instr_known;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = 0; m_ptr = 0;
        m_instr = 32'h0; m_valid = 0; m_err = 0;
        m_defined = 1; m_instr_known = 1;
    endtask

    task automatic model_edge();
        logic [31:0] moff;
        logic [31:0] midx;
        int          next_mode;
        next_mode = m_mode;
        m_valid   = 0;
        if (m_mode == 0) begin
            if (fetch_req) begin
                moff = Address - BASE;
                midx = moff / 4;
                m_valid = 1; m_defined = 1;
                if ((Address % 4 != 0) || (midx >= DEPTH)) begin
                    m_instr = 32'h0; m_err = 1; m_instr_known = 1;
                end else begin
                    m_instr = m_mem[midx]; m_err = 0; m_instr_known = m_known[midx];
                end
            end
            if (load_start) begin
                next_mode = 1; m_ptr = 0;
            end
        end else begin
            if (fetch_req) begin
                m_instr = 32'h0; m_err = 0; m_defined = 1; m_instr_known = 1;
            end else begin
                m_defined = 0;
            end
            if (m_mode == 1) begin
                if (load_valid) begin
                    m_mem[m_ptr] = load_data; m_known[m_ptr] = 1;
                    m_ptr++;
                    if (load_last || m_ptr == DEPTH) next_mode = 2;
                end
            end else begin
                next_mode = 0;
            end
        end
        m_mode = next_mode;
    endtask

    task automatic check_outputs();
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("load_ready", 32'(load_ready), 32'(m_mode == 1));
        chk("load_done", 32'(load_done), 32'(m_mode == 2));
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        if (m_defined) chk("addr_error", 32'(addr_error), 32'(m_err));
        if (m_defined && m_instr_known) chk("Instruction", Instruction, m_instr);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle();
        fetch_req = 0; Address = BASE; load_start = 0;
        load_valid = 0; load_last = 0; load_data = 32'h0;
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_req = 1; Address = a;
        cyc();
        fetch_req = 0;
    endtask

    task automatic do_load(input int n, input logic [31:0] first, input bit use_last, input bit gaps);
        load_start = 1; cyc(); load_start = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom % 3 == 0)) begin
                load_valid = 0; cyc();
            end
            load_valid = 1; load_data = first + 32'(i);
            load_last  = use_last && (i == n - 1);
            cyc();
        end
        load_valid = 0; load_last = 0;
        cyc();
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic async_reset();
        #3 reset = 1;
        #1 model_reset();
        check_outputs();
        #2 reset = 0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
        idle();
        reset = 1;
        model_reset();
        #2 check_outputs();
        #1 reset = 0;

        // Preload four words and fetch back to back.
        do_load(4, 32'h2008_0001, 1, 0);
        fetch(BASE + 32'h0);
        fetch(BASE + 32'h4);
        fetch(BASE + 32'hC);
        fetch(BASE + 32'h8);
        cyc();

        // Misaligned, past-the-end and below-base fetches.
        fetch(BASE + 32'h2);
        fetch(BASE + 32'h100);
        fetch(32'h003F_FFFC);
        fetch(BASE + 32'hFC);
        cyc();

        // Three-word load with a fetch held high throughout.
        fetch_req = 1; Address = BASE + 32'h4;
        do_load(3, 32'hAAAA_0001, 1, 0);
        fetch_req = 0;
        fetch(BASE + 32'h4);
        fetch(BASE + 32'h0);
        fetch(BASE + 32'h8);
        fetch(BASE + 32'hC);
        cyc();

        // Full-depth load that terminates without load_last.
        do_load(DEPTH, 32'h5000_0000, 0, 1);
        fetch(BASE + 32'hFC);
        fetch(BASE + 32'h0);
        cyc();

        // Reset in the middle of a five-word load after two words.
        load_start = 1; cyc(); load_start = 0;
        load_valid = 1; load_data = 32'hBBBB_0001; cyc();
        load_data = 32'hBBBB_0002; cyc();
        load_valid = 0;
        async_reset();
        cyc();
        fetch(BASE + 32'h0);
        fetch(BASE + 32'h4);
        fetch(BASE + 32'h8);
        do_load(1, 32'hCCCC_0001, 1, 0);
        fetch(BASE + 32'h0);
        fetch(BASE + 32'h4);
        cyc();

        // Random traffic on every input.
        for (int c = 0; c < 600; c++) begin
            fetch_req = 1'($urandom % 2);
            case ($urandom % 8)
                0, 1, 2, 3, 4: Address = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                5:             Address = (BASE + 32'($urandom_range(0, 255))) | 32'h1;
                6:             Address = BASE + 32'(4 * $urandom_range(DEPTH, 200));
                default:       Address = BASE - 32'(4 * $urandom_range(1, 10));
            endcase
            load_start = ($urandom % 20 == 0);
            load_valid = 1'($urandom % 2);
            load_last  = ($urandom % 6 == 0);
            load_data  = $urandom;
            cyc();
        end
        idle();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
